// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and the per-channel slew helper for the
// servo slew scheduler.
package servo_pkg;

  localparam int unsigned      POS_W              = 8;
  localparam logic [POS_W-1:0] POS_CENTER         = 8'd128;
  localparam int unsigned      FRAME_CYCLES_50MHZ = 1048576;
  localparam logic [POS_W-1:0] STEP_JUMP          = 8'd255;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_e;

  // One frame of motion toward tgt; 9-bit math clamps at the target, never wraps.
  function automatic logic [POS_W-1:0] slew_next(input logic [POS_W-1:0] cur,
                                                 input logic [POS_W-1:0] tgt,
                                                 input logic [POS_W-1:0] step);
    logic [POS_W:0] sum;
    logic [POS_W:0] diff;
    sum       = {1'b0, cur} + {1'b0, step};
    diff      = {1'b0, cur} - {1'b0, step};
    slew_next = cur;
    if (cur < tgt) begin
      slew_next = (sum > {1'b0, tgt}) ? tgt : sum[POS_W-1:0];
    end else if (cur > tgt) begin
      slew_next = (diff[POS_W] || (diff[POS_W-1:0] < tgt)) ? tgt : diff[POS_W-1:0];
    end
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter with a registered one-cycle tick on the last
// cycle of each frame.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_50MHZ,
  parameter int unsigned FRAME_W      = 20
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick
);

  localparam logic [FRAME_W-1:0] LAST = FRAME_W'(FRAME_CYCLES - 1);

  logic [FRAME_W-1:0] cnt_q;
  logic [FRAME_W-1:0] cnt_d;
  logic               tick_d;

  // Tick is asserted alongside the counter entering its last value.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: rtl/servo_slew_sched.sv
// Multi-channel servo scheduler: holds per-channel targets and, once per
// frame, slews each driven position toward its target one channel per cycle.
module servo_slew_sched
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CH_W         = 2,
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_50MHZ,
  parameter int unsigned FRAME_W      = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CH_W-1:0]         cmd_ch,
  input  logic [POS_W-1:0]        cmd_pos,
  input  logic [POS_W-1:0]        cmd_step,
  output logic [NUM_CH*POS_W-1:0] pos_out,
  output logic [NUM_CH-1:0]       moving,
  output logic                    frame_tick,
  output logic                    all_idle
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [POS_W-1:0]   cur_q  [NUM_CH];
  logic [POS_W-1:0]   cur_d  [NUM_CH];
  logic [POS_W-1:0]   tgt_q  [NUM_CH];
  logic [POS_W-1:0]   tgt_d  [NUM_CH];
  logic [POS_W-1:0]   step_q [NUM_CH];
  logic [POS_W-1:0]   step_d [NUM_CH];
  logic [NUM_CH-1:0]  moving_d;
  logic               cmd_ready_d;
  logic               all_idle_d;
  logic               accept_c;

  servo_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .FRAME_W      (FRAME_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick)
  );

  // cmd_ready is only ever high in IDLE, so it alone gates acceptance.
  assign accept_c = cmd_valid && cmd_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
    assign pos_out[g*POS_W +: POS_W] = cur_q[g];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    moving_d = '0;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    // Out-of-range channel indices match no slot and are silently dropped.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (accept_c && (cmd_ch == CH_W'(k))) begin
        tgt_d[k]  = cmd_pos;
        step_d[k] = (cmd_step == '0) ? STEP_JUMP : cmd_step;
      end
      if ((state_q == UPDATE) && (idx_q == IDX_W'(k))) begin
        cur_d[k] = slew_next(cur_q[k], tgt_q[k], step_q[k]);
      end
      moving_d[k] = (cur_d[k] != tgt_d[k]);
    end

    cmd_ready_d = (state_d == IDLE);
    all_idle_d  = (~|moving_d) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cmd_ready <= 1'b0;
      moving    <= '0;
      all_idle  <= 1'b1;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cur_q[k]  <= POS_CENTER;
        tgt_q[k]  <= POS_CENTER;
        step_q[k] <= POS_W'(1);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmd_ready <= cmd_ready_d;
      moving    <= moving_d;
      all_idle  <= all_idle_d;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cur_q[k]  <= cur_d[k];
        tgt_q[k]  <= tgt_d[k];
        step_q[k] <= step_d[k];
      end
    end
  end

endmodule

// File: tb/tb_servo_slew_sched.sv
// Bench for servo_slew_sched: directed scenarios plus random commands, checked
// every cycle against a frame/offset-based reference model.
module tb_servo_slew_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_ch = '0;
  logic [7:0]  cmd_pos = '0;
  logic [7:0]  cmd_step = '0;
  logic        cmd_ready;
  logic [31:0] pos_out;
  logic [3:0]  moving;
  logic        frame_tick;
  logic        all_idle;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  servo_slew_sched #(
    .NUM_CH       (4),
    .CH_W         (3),
    .FRAME_CYCLES (16),
    .FRAME_W      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_pos    (cmd_pos),
    .cmd_step   (cmd_step),
    .pos_out    (pos_out),
    .moving     (moving),
    .frame_tick (frame_tick),
    .all_idle   (all_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ch_pos(input int k);
    return int'(pos_out[8*k +: 8]);
  endfunction

  // Reference model: m_n is the index of the current cycle since reset release,
  // m_T the most recent tick cycle; channel k settles at cycle m_T+2+k.
  int m_cur [4];
  int m_tgt [4];
  int m_step[4];
  int m_n, m_T, m_off, m_ch;
  bit m_tick, m_started;

  function automatic int slew(input int c, input int t, input int s);
    if (c < t) return (c + s > t) ? t : c + s;
    if (c > t) return (c - s < t) ? t : c - s;
    return c;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_cur[k] = 128; m_tgt[k] = 128; m_step[k] = 1;
    end
    m_n = 0; m_T = -100; m_tick = 1'b0; m_started = 1'b0;
  endtask

  initial m_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reset();
    end else begin
      m_off = m_n - m_T;
      if (m_off >= 1 && m_off <= 4) begin
        m_ch = m_off - 1;
        m_cur[m_ch] = slew(m_cur[m_ch], m_tgt[m_ch], m_step[m_ch]);
      end
      if (cmd_valid && m_started && !(m_n > m_T && m_n <= m_T + 4)) begin
        m_ch = int'(cmd_ch);
        if (m_ch < 4) begin
          m_tgt[m_ch]  = int'(cmd_pos);
          m_step[m_ch] = (cmd_step == 8'd0) ? 255 : int'(cmd_step);
        end
      end
      if (m_tick) m_T = m_n;
      m_n++;
      m_started = 1'b1;
      m_tick = ((m_n % 16) == 15);
    end
  end

  int c_mov;
  bit c_upd;

  always @(negedge clk) begin
    if (chk_en) begin
      c_upd = (m_n > m_T) && (m_n <= m_T + 4);
      c_mov = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_cur[k] != m_tgt[k]) c_mov |= (1 << k);
        chk($sformatf("pos_out[%0d]", k), ch_pos(k), m_cur[k]);
      end
      chk("moving", int'(moving), c_mov);
      chk("frame_tick", int'(frame_tick), int'(m_tick));
      chk("cmd_ready", int'(cmd_ready), int'(m_started && !c_upd));
      chk("all_idle", int'(all_idle), int'((c_mov == 0) && !c_upd));
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL wait_tick: got no frame_tick expected one within 40 cycles");
    end
  endtask

  task automatic mid_frame();
    wait_tick();
    repeat (6) @(negedge clk);
  endtask

  task automatic send(input int ch, input int pos, input int stp, output bit ok);
    bit r;
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ch = 3'(ch); cmd_pos = 8'(pos); cmd_step = 8'(stp);
    for (int i = 0; i < 30; i++) begin
      r = cmd_ready;
      @(negedge clk);
      if (r) begin ok = 1'b1; break; end
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL send: got no handshake expected one for ch %0d", ch);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ticks, low, cyc;
    int exp1[3];
    exp1[0] = 133; exp1[1] = 138; exp1[2] = 140;

    // 1: reset and idle frames
    do_reset();
    chk_en = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      if (i == 1) chk("ready_after_reset", int'(cmd_ready), 1);
      if (frame_tick) ticks++;
    end
    chk("idle_tick_count", ticks, 3);
    chk("idle_pos_out", int'(pos_out == 32'h80808080), 1);

    // 2: ch1 -> 140 step 5
    mid_frame();
    send(1, 140, 5, ok);
    chk("ch1_moving_after_cmd", int'(moving[1]), 1);
    for (int f = 0; f < 3; f++) begin
      wait_tick();
      repeat (3) @(negedge clk);
      chk($sformatf("ch1_frame%0d", f), ch_pos(1), exp1[f]);
      chk($sformatf("ch1_moving_frame%0d", f), int'(moving[1]), (f < 2) ? 1 : 0);
    end

    // 3: clamp to 0 and jump to 255
    mid_frame();
    send(0, 0, 200, ok);
    send(3, 255, 0, ok);
    wait_tick();
    repeat (2) @(negedge clk);
    chk("ch0_clamp_T2", ch_pos(0), 0);
    repeat (2) @(negedge clk);
    chk("ch3_before_T5", ch_pos(3), 128);
    @(negedge clk);
    chk("ch3_jump_T5", ch_pos(3), 255);

    // 4: command held across the tick
    wait_tick();
    cmd_valid = 1'b1; cmd_ch = 3'd2; cmd_pos = 8'd100; cmd_step = 8'd1;
    low = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!cmd_ready) low++;
      if (i == 3) chk("ch2_before_T4", ch_pos(2), 128);
      if (i == 4) chk("ch2_at_T4", ch_pos(2), 127);
    end
    cmd_valid = 1'b0;
    chk("ready_low_cycles", low, 4);

    // 5: out-of-range channel, then last-write-wins burst
    do_reset();
    mid_frame();
    send(5, 10, 0, ok);
    chk("ch5_handshake", int'(ok), 1);
    cmd_valid = 1'b1; cmd_ch = 3'd2; cmd_pos = 8'd120; cmd_step = 8'd1;
    @(negedge clk);
    @(negedge clk);
    cmd_pos = 8'd130;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_tick();
    repeat (4) @(negedge clk);
    chk("ch2_burst_f1", ch_pos(2), 129);
    chk("ch2_moving_f1", int'(moving[2]), 1);
    wait_tick();
    repeat (4) @(negedge clk);
    chk("ch2_burst_f2", ch_pos(2), 130);
    chk("moving_f2", int'(moving), 0);
    chk("ch1_untouched", ch_pos(1), 128);
    chk("ch0_untouched", ch_pos(0), 128);
    chk("ch3_untouched", ch_pos(3), 128);

    // 6: reset in the middle of an update
    mid_frame();
    send(1, 200, 10, ok);
    wait_tick();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_pos_out", int'(pos_out == 32'h80808080), 1);
    chk("rst_moving", int'(moving), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_all_idle", int'(all_idle), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (frame_tick) begin cyc = i; break; end
    end
    chk("first_tick_after_rst", cyc, 15);
    chk("ch1_after_rst", ch_pos(1), 128);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_ch    = 3'($urandom_range(0, 5));
      case ($urandom_range(0, 5))
        0:       cmd_pos = 8'd0;
        1:       cmd_pos = 8'd255;
        default: cmd_pos = 8'($urandom);
      endcase
      cmd_step  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
